// File: rtl/mmio_timer_intc.sv
// Memory-mapped prescaled countdown timer plus edge-latched external interrupt controller.
// Answers single-cycle load/store requests on a 32-byte window and drives a 6-bit interrupt vector.
module mmio_timer_intc #(
  parameter logic [31:0] BASE_ADDR  = 32'h1FD0_0000,
  parameter int          PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  input  logic [3:0]  ext_irq_i,
  output logic [5:0]  int_o
);

  localparam logic [31:0] ID_VALUE = 32'h4D49_4F31;

  typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_DONE} state_t;

  state_t                state_reg, state_next;
  logic [2:0]            ctrl_reg, ctrl_next;
  logic [PRESCALE_W-1:0] prescale_reg, prescale_next;
  logic [PRESCALE_W-1:0] pcnt_reg, pcnt_next;
  logic [31:0]           load_reg, load_next;
  logic [31:0]           count_reg, count_next;
  logic [4:0]            pend_reg, pend_next;
  logic [4:0]            mask_reg, mask_next;
  logic [5:0]            int_reg, int_next;
  logic [3:0]            sync1_reg, sync2_reg, dly_reg;

  logic        hit, wr;
  logic [2:0]  reg_sel;
  logic [31:0] wmask;
  logic        wr_ctrl, wr_prescale, wr_load, wr_count, wr_pend, wr_mask;
  logic [2:0]  ctrl_wr;
  logic        en_sw, run_act, tick, expiry;
  logic [3:0]  ext_rise;
  logic        unused_bits;

  assign hit     = ce_i && (addr_i[31:5] == BASE_ADDR[31:5]);
  assign wr      = hit && we_i;
  assign reg_sel = addr_i[4:2];
  assign unused_bits = ^addr_i[1:0];

  assign wr_ctrl     = wr && (reg_sel == 3'd0);
  assign wr_prescale = wr && (reg_sel == 3'd1);
  assign wr_load     = wr && (reg_sel == 3'd2);
  assign wr_count    = wr && (reg_sel == 3'd3);
  assign wr_pend     = wr && (reg_sel == 3'd4);
  assign wr_mask     = wr && (reg_sel == 3'd5);

  // Per-lane byte mask and per-line rising-edge detect.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign wmask[8*gi +: 8] = {8{sel_i[gi]}};
      assign ext_rise[gi]     = sync2_reg[gi] & ~dly_reg[gi];
    end
  endgenerate

  assign ctrl_wr = (ctrl_reg & ~wmask[2:0]) | (data_i[2:0] & wmask[2:0]);

  // A CTRL write clearing EN halts counting in the same cycle.
  assign en_sw   = wr_ctrl ? ctrl_wr[0] : ctrl_reg[0];
  assign run_act = (state_reg == ST_RUN) && en_sw;
  assign tick    = run_act && (pcnt_reg == prescale_reg);
  assign expiry  = tick && (count_reg == 32'd0);

  always_comb begin
    state_next    = state_reg;
    ctrl_next     = ctrl_reg;
    prescale_next = prescale_reg;
    pcnt_next     = pcnt_reg;
    load_next     = load_reg;
    count_next    = count_reg;
    pend_next     = pend_reg;
    mask_next     = mask_reg;

    // Prescaler
    if (!run_act || tick) begin
      pcnt_next = '0;
    end else begin
      pcnt_next = pcnt_reg + PRESCALE_W'(1);
    end

    // Countdown and expiry handling
    if (tick) begin
      if (count_reg != 32'd0) begin
        count_next = count_reg - 32'd1;
      end else if (ctrl_reg[1]) begin
        count_next = load_reg;
      end else begin
        ctrl_next[0] = 1'b0;
      end
    end

    // Software writes take precedence over same-cycle hardware updates.
    if (wr_ctrl) begin
      ctrl_next = ctrl_wr;
    end
    if (wr_prescale) begin
      prescale_next = (prescale_reg & ~wmask[PRESCALE_W-1:0]) |
                      (data_i[PRESCALE_W-1:0] & wmask[PRESCALE_W-1:0]);
    end
    if (wr_load) begin
      load_next = (load_reg & ~wmask) | (data_i & wmask);
    end
    if (wr_count) begin
      count_next = (count_reg & ~wmask) | (data_i & wmask);
      pcnt_next  = '0;
    end
    if (wr_mask) begin
      mask_next = (mask_reg & ~wmask[4:0]) | (data_i[4:0] & wmask[4:0]);
    end

    // Hardware set wins over a same-cycle write-1-to-clear.
    if (wr_pend) begin
      pend_next = pend_reg & ~(data_i[4:0] & wmask[4:0]);
    end
    pend_next = pend_next | {ext_rise, expiry};

    case (state_reg)
      ST_STOP: begin
        if (ctrl_next[0]) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!ctrl_next[0]) begin
          state_next = expiry ? ST_DONE : ST_STOP;
        end
      end
      ST_DONE: begin
        state_next = ST_STOP;
      end
      default: begin
        state_next = ST_STOP;
      end
    endcase
  end

  assign int_next = {pend_reg[0] & mask_reg[0] & ctrl_reg[2], 1'b0,
                     pend_reg[4:1] & mask_reg[4:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_STOP;
      ctrl_reg     <= '0;
      prescale_reg <= '0;
      pcnt_reg     <= '0;
      load_reg     <= '0;
      count_reg    <= '0;
      pend_reg     <= '0;
      mask_reg     <= '0;
      int_reg      <= '0;
      sync1_reg    <= '0;
      sync2_reg    <= '0;
      dly_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      ctrl_reg     <= ctrl_next;
      prescale_reg <= prescale_next;
      pcnt_reg     <= pcnt_next;
      load_reg     <= load_next;
      count_reg    <= count_next;
      pend_reg     <= pend_next;
      mask_reg     <= mask_next;
      int_reg      <= int_next;
      sync1_reg    <= ext_irq_i;
      sync2_reg    <= sync1_reg;
      dly_reg      <= sync2_reg;
    end
  end

  assign int_o = int_reg;

  // Zero-latency read path; writes and misses return 0.
  always_comb begin
    data_o = '0;
    if (hit && !we_i) begin
      case (reg_sel)
        3'd0:    data_o = {29'd0, ctrl_reg};
        3'd1:    data_o = 32'(prescale_reg);
        3'd2:    data_o = load_reg;
        3'd3:    data_o = count_reg;
        3'd4:    data_o = {27'd0, pend_reg};
        3'd5:    data_o = {27'd0, mask_reg};
        3'd6:    data_o = ID_VALUE;
        default: data_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_timer_intc.sv
// Self-checking bench for mmio_timer_intc: register-access vector table plus
// hand-written timer, interrupt, reset and collision sequences.
module tb_mmio_timer_intc;

  localparam logic [31:0] BASE = 32'h1FD0_0000;
  localparam logic [31:0] ID   = 32'h4D49_4F31;

  logic        clk;
  logic        rst;
  logic        ce_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [3:0]  sel_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic [3:0]  ext_irq_i;
  logic [5:0]  int_o;

  int total_cnt;
  int pass_cnt;

  mmio_timer_intc #(.BASE_ADDR(BASE), .PRESCALE_W(16)) dut (
    .clk(clk), .rst(rst), .ce_i(ce_i), .we_i(we_i), .addr_i(addr_i),
    .sel_i(sel_i), .data_i(data_i), .data_o(data_o),
    .ext_irq_i(ext_irq_i), .int_o(int_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] off;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) begin
      pass_cnt++;
      $display("ok   %s: got %h", name, got);
    end else begin
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Combinational read inside the current cycle; no clock edge consumed.
  task automatic peek(input logic [31:0] off, output logic [31:0] val);
    ce_i = 1'b1; we_i = 1'b0; addr_i = BASE + off; sel_i = 4'hF;
    #1;
    val = data_o;
    ce_i = 1'b0;
  endtask

  // Write spanning exactly one clock edge; returns 1 time unit after that edge.
  task automatic bus_write(input logic [31:0] off, input logic [3:0] sel,
                           input logic [31:0] wdata, output logic [31:0] rd);
    ce_i = 1'b1; we_i = 1'b1; addr_i = BASE + off; sel_i = sel; data_i = wdata;
    #1;
    rd = data_o;
    @(posedge clk); #1;
    ce_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] wdata);
    logic [31:0] dummy;
    bus_write(off, 4'hF, wdata, dummy);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  logic [31:0] rv;
  logic        seen;
  logic [31:0] cnt_exp_auto[7];
  logic [31:0] cnt_exp_one[4];

  initial begin
    total_cnt = 0; pass_cnt = 0;
    rst = 1'b1; ce_i = 1'b0; we_i = 1'b0; addr_i = '0; sel_i = '0;
    data_i = '0; ext_irq_i = '0;

    vecs[0]  = '{32'h18, 1'b0, 4'hF, 32'h0,         ID};
    vecs[1]  = '{32'h1C, 1'b0, 4'hF, 32'h0,         32'h0};
    vecs[2]  = '{32'h20, 1'b0, 4'hF, 32'h0,         32'h0};
    vecs[3]  = '{32'h08, 1'b0, 4'hF, 32'h0,         32'h0};
    vecs[4]  = '{32'h08, 1'b1, 4'hF, 32'hFFFF_FFFF, 32'h0};
    vecs[5]  = '{32'h08, 1'b0, 4'hF, 32'h0,         32'hFFFF_FFFF};
    vecs[6]  = '{32'h08, 1'b1, 4'h3, 32'h1234_5678, 32'h0};
    vecs[7]  = '{32'h08, 1'b0, 4'hF, 32'h0,         32'hFFFF_5678};
    vecs[8]  = '{32'h28, 1'b1, 4'hF, 32'h0,         32'h0};
    vecs[9]  = '{32'h08, 1'b0, 4'hF, 32'h0,         32'hFFFF_5678};
    vecs[10] = '{32'h04, 1'b1, 4'hF, 32'hABCD_1234, 32'h0};
    vecs[11] = '{32'h04, 1'b0, 4'hF, 32'h0,         32'h0000_1234};
    vecs[12] = '{32'h14, 1'b1, 4'hF, 32'hFFFF_FFFF, 32'h0};
    vecs[13] = '{32'h14, 1'b0, 4'hF, 32'h0,         32'h0000_001F};
    vecs[14] = '{32'h18, 1'b1, 4'hF, 32'h0,         32'h0};
    vecs[15] = '{32'h18, 1'b0, 4'hF, 32'h0,         ID};
    vecs[16] = '{32'h00, 1'b1, 4'hF, 32'hFFFF_FFF6, 32'h0};
    vecs[17] = '{32'h00, 1'b0, 4'hF, 32'h0,         32'h0000_0006};
    vecs[18] = '{32'h0C, 1'b1, 4'h4, 32'h00AB_0000, 32'h0};
    vecs[19] = '{32'h0C, 1'b0, 4'hF, 32'h0,         32'h00AB_0000};
    vecs[20] = '{32'h08, 1'b1, 4'h0, 32'hFFFF_FFFF, 32'h0};
    vecs[21] = '{32'h08, 1'b0, 4'hF, 32'h0,         32'hFFFF_5678};

    cnt_exp_auto = '{32'd2, 32'd1, 32'd1, 32'd0, 32'd0, 32'd2, 32'd2};
    cnt_exp_one  = '{32'd2, 32'd1, 32'd0, 32'd0};

    // Power-on reset
    #22;
    check("reset_int_o", 32'(int_o), 32'h0);
    check("idle_data_o", data_o, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Register access table
    for (int i = 0; i < 22; i++) begin
      if (vecs[i].we) begin
        bus_write(vecs[i].off, vecs[i].sel, vecs[i].wdata, rv);
      end else begin
        peek(vecs[i].off, rv);
        step(1);
      end
      check($sformatf("vec%0d_off%0h_we%0d", i, vecs[i].off, vecs[i].we), rv, vecs[i].exp_rd);
    end

    // Reset asserted mid-count with a pending interrupt
    wr(32'h04, 32'd0);
    wr(32'h0C, 32'd100);
    wr(32'h00, 32'd1);
    ext_irq_i[0] = 1'b1;
    step(4);
    ext_irq_i[0] = 1'b0;
    peek(32'h0C, rv); check("pre_rst_count", rv, 32'd96);
    peek(32'h10, rv); check("pre_rst_pend", rv, 32'h2);
    step(1);
    check("pre_rst_int_o", 32'(int_o), 32'h01);
    #2 rst = 1'b1;
    #1 check("rst_int_o_async", 32'(int_o), 32'h0);
    step(2);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    peek(32'h00, rv); check("rst_ctrl", rv, 32'h0);
    peek(32'h04, rv); check("rst_prescale", rv, 32'h0);
    peek(32'h08, rv); check("rst_load", rv, 32'h0);
    peek(32'h0C, rv); check("rst_count", rv, 32'h0);
    peek(32'h10, rv); check("rst_pend", rv, 32'h0);
    peek(32'h14, rv); check("rst_mask", rv, 32'h0);
    peek(32'h18, rv); check("rst_id", rv, ID);
    step(3);
    peek(32'h0C, rv); check("rst_count_held", rv, 32'h0);

    // Auto-reload: PRESCALE=1, LOAD=2, COUNT=2 -> expiry every 6 edges
    wr(32'h04, 32'd1);
    wr(32'h08, 32'd2);
    wr(32'h0C, 32'd2);
    wr(32'h14, 32'd1);
    wr(32'h00, 32'h7);
    for (int k = 1; k <= 7; k++) begin
      step(1);
      peek(32'h10, rv);
      check($sformatf("auto_pend0_e%0d", k), 32'(rv[0]), 32'(k >= 6));
      check($sformatf("auto_int5_e%0d", k), 32'(int_o[5]), 32'(k >= 7));
      peek(32'h0C, rv);
      check($sformatf("auto_count_e%0d", k), rv, cnt_exp_auto[k-1]);
    end
    wr(32'h10, 32'h1);
    peek(32'h10, rv); check("w1c_pend0_e8", 32'(rv[0]), 32'h0);
    check("w1c_int5_e8", 32'(int_o[5]), 32'h1);
    step(1);
    check("w1c_int5_e9", 32'(int_o[5]), 32'h0);
    for (int k = 10; k <= 12; k++) begin
      step(1);
      peek(32'h10, rv);
      check($sformatf("auto2_pend0_e%0d", k), 32'(rv[0]), 32'(k == 12));
    end
    step(5);
    wr(32'h10, 32'h1);
    peek(32'h10, rv); check("collide_w1c_expiry_pend0", 32'(rv[0]), 32'h1);
    peek(32'h0C, rv); check("collide_reload_count", rv, 32'd2);
    step(1);
    wr(32'h0C, 32'd10);
    peek(32'h0C, rv); check("collide_count_write_tick", rv, 32'd10);
    step(1);
    peek(32'h0C, rv); check("count_after_write_e21", rv, 32'd10);
    step(1);
    peek(32'h0C, rv); check("count_after_write_e22", rv, 32'd9);
    wr(32'h00, 32'h6);
    step(3);
    peek(32'h0C, rv); check("stop_count_kept", rv, 32'd9);

    // One-shot: PRESCALE=0, COUNT=3 -> expiry at edge 4
    wr(32'h10, 32'h1F);
    wr(32'h04, 32'd0);
    wr(32'h0C, 32'd3);
    wr(32'h00, 32'h1);
    for (int k = 1; k <= 4; k++) begin
      step(1);
      peek(32'h10, rv);
      check($sformatf("oneshot_pend0_e%0d", k), 32'(rv[0]), 32'(k == 4));
      peek(32'h0C, rv);
      check($sformatf("oneshot_count_e%0d", k), rv, cnt_exp_one[k-1]);
    end
    peek(32'h00, rv); check("oneshot_en_cleared", 32'(rv[0]), 32'h0);
    wr(32'h10, 32'h1);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step(1);
      peek(32'h10, rv);
      seen = seen | rv[0];
    end
    check("oneshot_no_second_expiry", 32'(seen), 32'h0);
    peek(32'h0C, rv); check("oneshot_count_zero", rv, 32'h0);

    // External edge on line 2 -> PEND[3], int_o[2]
    wr(32'h14, 32'h08);
    wr(32'h10, 32'h1F);
    ext_irq_i[2] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step(1);
      if (k == 3) ext_irq_i[2] = 1'b0;
      peek(32'h10, rv);
      check($sformatf("ext_pend3_e%0d", k), 32'(rv[3]), 32'(k >= 3));
      check($sformatf("ext_int2_e%0d", k), 32'(int_o[2]), 32'(k >= 4));
    end
    check("ext_int4_zero", 32'(int_o[4]), 32'h0);
    wr(32'h10, 32'h08);
    peek(32'h10, rv); check("ext_w1c_pend3", 32'(rv[3]), 32'h0);
    step(1);
    check("ext_w1c_int2_fall", 32'(int_o[2]), 32'h0);

    ext_irq_i[2] = 1'b1;
    step(4);
    peek(32'h10, rv); check("level_pend3_set", 32'(rv[3]), 32'h1);
    wr(32'h10, 32'h08);
    step(5);
    peek(32'h10, rv); check("level_no_reset_pend3", 32'(rv[3]), 32'h0);
    check("level_int2_low", 32'(int_o[2]), 32'h0);

    ext_irq_i[2] = 1'b0;
    step(4);
    wr(32'h14, 32'h0);
    ext_irq_i[2] = 1'b1;
    step(5);
    peek(32'h10, rv); check("masked_pend3_set", 32'(rv[3]), 32'h1);
    check("masked_int_o_zero", 32'(int_o), 32'h0);
    ext_irq_i[2] = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
